// File: rtl/plot_arbiter.sv
// Two-requester burst arbiter in front of the vga_adapter pixel port.
// Round-robin between bursts, MAX_BURST cap while the other side waits.
module plot_arbiter #(
    parameter int X_W       = 8,
    parameter int Y_W       = 7,
    parameter int C_W       = 3,
    parameter int MAX_BURST = 64
) (
    input  logic           clk,
    input  logic           resetn,
    input  logic           r0_valid,
    input  logic           r0_last,
    input  logic [X_W-1:0] r0_x,
    input  logic [Y_W-1:0] r0_y,
    input  logic [C_W-1:0] r0_c,
    output logic           r0_ready,
    input  logic           r1_valid,
    input  logic           r1_last,
    input  logic [X_W-1:0] r1_x,
    input  logic [Y_W-1:0] r1_y,
    input  logic [C_W-1:0] r1_c,
    output logic           r1_ready,
    output logic [X_W-1:0] x,
    output logic [Y_W-1:0] y,
    output logic [C_W-1:0] colour,
    output logic           plot,
    output logic [1:0]     grant
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_GNT0 = 2'd1;
    localparam logic [1:0] S_GNT1 = 2'd2;

    localparam logic [7:0] CNT_TOP = 8'(MAX_BURST - 1);

    logic [1:0]     state_q, state_d;
    logic           rr_q, rr_d;
    logic [7:0]     cnt_q, cnt_d;
    logic [X_W-1:0] x_q;
    logic [Y_W-1:0] y_q;
    logic [C_W-1:0] c_q;
    logic           plot_q;

    logic own0, own1;
    logic beat;
    logic cur_last;
    logic oth_valid;
    logic at_top;
    logic rel;

    assign own0 = (state_q == S_GNT0);
    assign own1 = (state_q == S_GNT1);

    assign r0_ready = own0;
    assign r1_ready = own1;
    assign grant    = {own1, own0};

    assign beat      = (own0 & r0_valid) | (own1 & r1_valid);
    assign cur_last  = own1 ? r1_last  : r0_last;
    assign oth_valid = own1 ? r0_valid : r1_valid;
    assign at_top    = (cnt_q == CNT_TOP);
    assign rel       = beat & (cur_last | (at_top & oth_valid));

    assign x      = x_q;
    assign y      = y_q;
    assign colour = c_q;
    assign plot   = plot_q;

    // Next grant owner, round-robin pointer and burst beat counter.
    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (r0_valid & r1_valid) begin
                    state_d = rr_q ? S_GNT1 : S_GNT0;
                end else if (r0_valid) begin
                    state_d = S_GNT0;
                end else if (r1_valid) begin
                    state_d = S_GNT1;
                end
            end
            S_GNT0, S_GNT1: begin
                if (rel) begin
                    rr_d  = own0;
                    cnt_d = '0;
                    if (oth_valid) begin
                        state_d = own0 ? S_GNT1 : S_GNT0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else if (beat) begin
                    cnt_d = at_top ? '0 : cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Arbitration state registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            rr_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            cnt_q   <= cnt_d;
        end
    end

    // Registered pixel port: capture the accepted pixel, strobe plot once.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            x_q    <= '0;
            y_q    <= '0;
            c_q    <= '0;
            plot_q <= 1'b0;
        end else begin
            plot_q <= beat;
            if (beat) begin
                x_q <= own1 ? r1_x : r0_x;
                y_q <= own1 ? r1_y : r0_y;
                c_q <= own1 ? r1_c : r0_c;
            end
        end
    end

endmodule
